mprj_io_cfg_loader: RTL and testbench

Serial configuration sequencer for the user-project pad ring. It reads one configuration word per `mprj_io` pad from the housekeeping register file and shifts the words into the two daisy-chained GPIO control-block chains (lower half and upper half of the pads). It then pulses the load strobe, which latches the pad modes (`dm`, `oeb`, `inp_dis`, `vtrip_sel`, …). It sits between housekeeping and the per-pad control blocks that drive the pad ring.

---
 rtl/mprj_io_cfg_loader.sv | 173 +++++++++++++++++
 tb/tb_mprj_io_cfg_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_cfg_loader.sv
// Serial configuration sequencer: fetches one word per mprj_io pad and shifts it into the two GPIO control chains.
// Optional feature: define MPRJ_CFG_LOADER_AUTOSTART_EN to run one load sequence automatically after reset.
module mprj_io_cfg_loader #(
  parameter int NUM_PADS = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic                        clock,
  input  logic                        resetb,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_PADS)-1:0] cfg_addr1,
  output logic [$clog2(NUM_PADS)-1:0] cfg_addr2,
  input  logic [CFG_BITS-1:0]         cfg_data1,
  input  logic [CFG_BITS-1:0]         cfg_data2,
  output logic                        serial_clock,
  output logic                        serial_load,
  output logic                        serial_resetn,
  output logic                        serial_data_1,
  output logic                        serial_data_2
);

  localparam int HALF   = NUM_PADS / 2;
  localparam int ADDR_W = $clog2(NUM_PADS);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
  localparam int K_W    = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    LOAD,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic                phase;
  logic [BIT_W-1:0]    bit_cnt;
  logic [K_W-1:0]      word_cnt;
  logic                fetch_cnt;
  logic [CFG_BITS-1:0] shift1;
  logic [CFG_BITS-1:0] shift2;
  logic                auto_pending;
  logic                go;
  logic                period_end;

`ifdef MPRJ_CFG_LOADER_AUTOSTART_EN
  // Armed by reset, consumed by the first IDLE cycle after release.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      auto_pending <= 1'b1;
    end else if (state == IDLE) begin
      auto_pending <= 1'b0;
    end
  end
`else
  assign auto_pending = 1'b0;
`endif

  assign go         = start | auto_pending;
  assign period_end = (div_cnt == DIV_LAST) && phase;

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state         <= IDLE;
      serial_resetn <= 1'b0;
    end else begin
      state         <= state_next;
      serial_resetn <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    busy          = 1'b1;
    done          = 1'b0;
    serial_clock  = 1'b0;
    serial_load   = 1'b0;
    serial_data_1 = 1'b0;
    serial_data_2 = 1'b0;
    cfg_addr1     = '0;
    cfg_addr2     = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_next = FETCH;
      end
      FETCH: begin
        // Farthest block of each chain is fetched first.
        cfg_addr1 = ADDR_W'(HALF - 1) - ADDR_W'(word_cnt);
        cfg_addr2 = ADDR_W'(HALF) + ADDR_W'(word_cnt);
        if (fetch_cnt) state_next = SHIFT;
      end
      SHIFT: begin
        serial_clock  = phase;
        serial_data_1 = shift1[CFG_BITS-1];
        serial_data_2 = shift2[CFG_BITS-1];
        if (period_end && (bit_cnt == BIT_LAST)) begin
          state_next = (word_cnt == K_LAST) ? LOAD : FETCH;
        end
      end
      LOAD: begin
        serial_load = phase;
        if (period_end) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      fetch_cnt <= 1'b0;
      shift1    <= '0;
      shift2    <= '0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt   <= '0;
          phase     <= 1'b0;
          bit_cnt   <= '0;
          word_cnt  <= '0;
          fetch_cnt <= 1'b0;
        end
        FETCH: begin
          if (!fetch_cnt) begin
            fetch_cnt <= 1'b1;
          end else begin
            fetch_cnt <= 1'b0;
            shift1    <= cfg_data1;
            shift2    <= cfg_data2;
          end
        end
        SHIFT, LOAD: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            phase   <= ~phase;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
          // Advance to the next bit only once the high phase has finished.
          if ((state == SHIFT) && period_end) begin
            shift1 <= {shift1[CFG_BITS-2:0], 1'b0};
            shift2 <= {shift2[CFG_BITS-2:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              bit_cnt  <= '0;
              word_cnt <= word_cnt + 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Self-checking bench for mprj_io_cfg_loader: three parameterisations checked cycle by cycle
// against a timing model derived from word/bit arithmetic.
module tb_mprj_io_cfg_loader;

  localparam int NP0 = 4;
  localparam int CB0 = 4;
  localparam int CD0 = 1;
  localparam int NP1 = 38;
  localparam int CB1 = 13;
  localparam int CD1 = 2;
  localparam int NP2 = 6;
  localparam int CB2 = 5;
  localparam int CD2 = 3;
  localparam int AW0 = $clog2(NP0);
  localparam int AW1 = $clog2(NP1);
  localparam int AW2 = $clog2(NP2);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] start_v;
  logic [2:0] resetb_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] sclk_v;
  logic [2:0] sload_v;
  logic [2:0] srstn_v;
  logic [2:0] sd1_v;
  logic [2:0] sd2_v;

  logic [AW0-1:0] a1_0, a2_0;
  logic [AW1-1:0] a1_1, a2_1;
  logic [AW2-1:0] a1_2, a2_2;
  logic [CB0-1:0] d1_0, d2_0;
  logic [CB1-1:0] d1_1, d2_1;
  logic [CB2-1:0] d1_2, d2_2;

  logic [12:0] mem [3][38];
  int np_a [3] = '{NP0, NP1, NP2};
  int cb_a [3] = '{CB0, CB1, CB2};
  int cd_a [3] = '{CD0, CD1, CD2};

  int errors = 0;
  int checks = 0;

  mprj_io_cfg_loader #(.NUM_PADS(NP0), .CFG_BITS(CB0), .CLK_DIV(CD0)) dut0 (
    .clock(clock), .resetb(resetb_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .cfg_addr1(a1_0), .cfg_addr2(a2_0), .cfg_data1(d1_0), .cfg_data2(d2_0),
    .serial_clock(sclk_v[0]), .serial_load(sload_v[0]), .serial_resetn(srstn_v[0]),
    .serial_data_1(sd1_v[0]), .serial_data_2(sd2_v[0]));

  mprj_io_cfg_loader #(.NUM_PADS(NP1), .CFG_BITS(CB1), .CLK_DIV(CD1)) dut1 (
    .clock(clock), .resetb(resetb_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .cfg_addr1(a1_1), .cfg_addr2(a2_1), .cfg_data1(d1_1), .cfg_data2(d2_1),
    .serial_clock(sclk_v[1]), .serial_load(sload_v[1]), .serial_resetn(srstn_v[1]),
    .serial_data_1(sd1_v[1]), .serial_data_2(sd2_v[1]));

  mprj_io_cfg_loader #(.NUM_PADS(NP2), .CFG_BITS(CB2), .CLK_DIV(CD2)) dut2 (
    .clock(clock), .resetb(resetb_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .cfg_addr1(a1_2), .cfg_addr2(a2_2), .cfg_data1(d1_2), .cfg_data2(d2_2),
    .serial_clock(sclk_v[2]), .serial_load(sload_v[2]), .serial_resetn(srstn_v[2]),
    .serial_data_1(sd1_v[2]), .serial_data_2(sd2_v[2]));

  // Housekeeping register file model: one cycle read latency.
  always @(posedge clock) begin
    d1_0 <= mem[0][a1_0][CB0-1:0];
    d2_0 <= mem[0][a2_0][CB0-1:0];
    d1_1 <= mem[1][a1_1][CB1-1:0];
    d2_1 <= mem[1][a2_1][CB1-1:0];
    d1_2 <= mem[2][a1_2][CB2-1:0];
    d2_2 <= mem[2][a2_2][CB2-1:0];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_addr1(input int id);
    case (id)
      0: return 64'(a1_0);
      1: return 64'(a1_1);
      default: return 64'(a1_2);
    endcase
  endfunction

  function automatic logic [63:0] get_addr2(input int id);
    case (id)
      0: return 64'(a2_0);
      1: return 64'(a2_1);
      default: return 64'(a2_2);
    endcase
  endfunction

  task automatic check_reset(input int id, input string tag);
    check({tag, "_busy"},   64'(busy_v[id]),  64'd0);
    check({tag, "_done"},   64'(done_v[id]),  64'd0);
    check({tag, "_sclk"},   64'(sclk_v[id]),  64'd0);
    check({tag, "_sload"},  64'(sload_v[id]), 64'd0);
    check({tag, "_srstn"},  64'(srstn_v[id]), 64'd0);
    check({tag, "_sd1"},    64'(sd1_v[id]),   64'd0);
    check({tag, "_sd2"},    64'(sd2_v[id]),   64'd0);
    check({tag, "_addr1"},  get_addr1(id),    64'd0);
    check({tag, "_addr2"},  get_addr2(id),    64'd0);
  endtask

  task automatic fill_random(input int id);
    for (int i = 0; i < np_a[id]; i++) begin
      mem[id][i] = 13'($urandom_range(0, (1 << cb_a[id]) - 1));
    end
  endtask

  // Runs nseq back-to-back sequences (start held high when nseq>1) and compares every cycle
  // with the model; abort_at>0 pulls resetb low at that cycle instead of finishing.
  task automatic run_seq(input int id, input string tag, input int nseq, input bit auto_start,
                         input int abort_at);
    int half, cb, cd, w, sh, t, p, m, k, off, q, b;
    int bad_ctl, bad_clk, bad_load, bad_d1, bad_d2, bad_addr;
    int rises, loads, done_at;
    logic e_busy, e_done, e_clk, e_load, e_d1, e_d2, prev_clk, prev_load;
    logic [12:0] w1, w2;
    bit e1 [$];
    bit e2 [$];
    half = np_a[id] / 2;
    cb = cb_a[id];
    cd = cd_a[id];
    w = 2 + 2 * cd * cb;
    sh = half * w;
    t = sh + 2 * cd + 1;
    p = t + 1;
    for (int j = 0; j < half; j++) begin
      w1 = mem[id][half - 1 - j];
      w2 = mem[id][half + j];
      for (int i = 0; i < cb; i++) begin
        e1.push_back(w1[cb - 1 - i]);
        e2.push_back(w2[cb - 1 - i]);
      end
    end
    bad_ctl = 0; bad_clk = 0; bad_load = 0; bad_d1 = 0; bad_d2 = 0; bad_addr = 0;
    rises = 0; loads = 0; done_at = -1; prev_clk = 1'b0; prev_load = 1'b0;
    @(negedge clock);
    if (auto_start) resetb_v[id] = 1'b1;
    else start_v[id] = 1'b1;
    for (int c = 1; c <= nseq * p; c++) begin
      @(negedge clock);
      m = (c - 1) % p + 1;
      e_busy = (m <= t);
      e_done = (m == t);
      e_clk = 1'b0; e_load = 1'b0; e_d1 = 1'b0; e_d2 = 1'b0;
      if (m <= sh) begin
        k = (m - 1) / w;
        off = (m - 1) % w;
        if (off == 0) begin
          if (get_addr1(id) !== 64'(half - 1 - k) || get_addr2(id) !== 64'(half + k)) bad_addr++;
        end else if (off >= 2) begin
          b = (off - 2) / (2 * cd);
          e_clk = ((off - 2) % (2 * cd)) >= cd;
          e_d1 = e1[k * cb + b];
          e_d2 = e2[k * cb + b];
        end
      end else if (m <= sh + 2 * cd) begin
        q = m - sh - 1;
        e_load = (q >= cd);
      end
      if (busy_v[id] !== e_busy || done_v[id] !== e_done || srstn_v[id] !== 1'b1) bad_ctl++;
      if (sclk_v[id] !== e_clk) bad_clk++;
      if (sload_v[id] !== e_load) bad_load++;
      if (sd1_v[id] !== e_d1) bad_d1++;
      if (sd2_v[id] !== e_d2) bad_d2++;
      if (sclk_v[id] === 1'b1 && prev_clk === 1'b0) rises++;
      if (sload_v[id] === 1'b1 && prev_load === 1'b0) loads++;
      if (done_v[id] === 1'b1 && done_at < 0) done_at = c;
      prev_clk = sclk_v[id];
      prev_load = sload_v[id];
      if (nseq == 1 || c == nseq * p) start_v[id] = 1'b0;
      if (c == abort_at) begin
        resetb_v[id] = 1'b0;
        break;
      end
    end
    check({tag, "_ctl_bad_cycles"},  64'(bad_ctl),  64'd0);
    check({tag, "_sclk_bad_cycles"}, 64'(bad_clk),  64'd0);
    check({tag, "_load_bad_cycles"}, 64'(bad_load), 64'd0);
    check({tag, "_sd1_bad_cycles"},  64'(bad_d1),   64'd0);
    check({tag, "_sd2_bad_cycles"},  64'(bad_d2),   64'd0);
    check({tag, "_addr_bad_words"},  64'(bad_addr), 64'd0);
    if (abort_at > 0) begin
      @(negedge clock);
      check_reset(id, {tag, "_rst"});
      check({tag, "_load_pulses"}, 64'(loads + 32'(sload_v[id])), 64'd0);
    end else begin
      check({tag, "_sclk_rises"},  64'(rises),   64'(nseq * half * cb));
      check({tag, "_load_pulses"}, 64'(loads),   64'(nseq));
      check({tag, "_done_cycle"},  64'(done_at), 64'(t));
    end
  endtask

  // Releases reset; with autostart the block must run a full sequence by itself, otherwise it idles.
  task automatic release_reset(input int id, input string tag);
`ifdef MPRJ_CFG_LOADER_AUTOSTART_EN
    run_seq(id, {tag, "_auto"}, 1, 1'b1, 0);
`else
    @(negedge clock);
    resetb_v[id] = 1'b1;
    repeat (3) @(negedge clock);
    check({tag, "_idle_busy"},  64'(busy_v[id]),  64'd0);
    check({tag, "_idle_srstn"}, 64'(srstn_v[id]), 64'd1);
`endif
  endtask

  initial begin
    start_v = 3'b000;
    resetb_v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 38; j++) mem[i][j] = '0;
    end
    repeat (3) @(negedge clock);
    check_reset(0, "reset0");
    check_reset(1, "reset1");
    check_reset(2, "reset2");
    release_reset(0, "rel0");
    release_reset(1, "rel1");
    release_reset(2, "rel2");

    // Small directed case: chain 1 sees 0x2 then 0x1, chain 2 sees 0x3 then 0x4.
    mem[0][0] = 13'h1; mem[0][1] = 13'h2; mem[0][2] = 13'h3; mem[0][3] = 13'h4;
    run_seq(0, "small_directed", 1, 1'b0, 0);
    run_seq(0, "small_hold", 2, 1'b0, 0);
    for (int r = 0; r < 3; r++) begin
      fill_random(0);
      run_seq(0, "small_random", 1, 1'b0, 0);
    end

    for (int j = 0; j < NP1; j++) mem[1][j] = 13'h1FFF;
    run_seq(1, "default_ones", 1, 1'b0, 0);
    fill_random(1);
    run_seq(1, "default_abort", 1, 1'b0, 300);
    release_reset(1, "rel1b");
    fill_random(1);
    run_seq(1, "default_after_reset", 1, 1'b0, 0);

    fill_random(2);
    run_seq(2, "div3", 1, 1'b0, 0);
    fill_random(2);
    run_seq(2, "div3_hold", 2, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
